// File: rtl/load_store_buffer_pkg.sv
// Shared types and constants for the load/store buffer:
// op codes, access sizes, queue entry layout and issue FSM states.
package load_store_buffer_pkg;

    localparam int DEPTH       = 8;
    localparam int FULL_MARGIN = 1;

    localparam logic [4:0] OP_LB  = 5'd0;
    localparam logic [4:0] OP_LH  = 5'd1;
    localparam logic [4:0] OP_LW  = 5'd2;
    localparam logic [4:0] OP_LBU = 5'd3;
    localparam logic [4:0] OP_LHU = 5'd4;
    localparam logic [4:0] OP_SB  = 5'd5;
    localparam logic [4:0] OP_SH  = 5'd6;
    localparam logic [4:0] OP_SW  = 5'd7;
    localparam logic [4:0] OP_NOP = 5'd31;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  rob;
        logic        committed;
    } lsb_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } lsb_state_e;

    function automatic logic is_load(input logic [4:0] op);
        return op <= OP_LHU;
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [4:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            OP_LW, OP_SW:         return SIZE_W;
            default:              return SIZE_B;
        endcase
    endfunction

endpackage

// File: rtl/load_store_buffer_extend.sv
// Load result extension: right-aligned memory data to a 32-bit value.
// Ports: op_i (load op code), rdata_i (raw data), value_o (extended).
module load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] value_o
);

    always_comb begin
        value_o = rdata_i;
        case (op_i)
            OP_LB:   value_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            OP_LH:   value_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            OP_LBU:  value_o = {24'd0, rdata_i[7:0]};
            OP_LHU:  value_o = {16'd0, rdata_i[15:0]};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order 8-entry load/store queue between address unit and data memory.
// In: addr/op/rob_number/ls_value, commit_*, flush, mem_ready/mem_rdata.
// Out: full, mem_* request, cdb_* load result, st_ready_* store notice.
module load_store_buffer
    import load_store_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [4:0]  op,
    input  logic [2:0]  rob_number,
    input  logic [31:0] ls_value,
    input  logic        commit_valid,
    input  logic [2:0]  commit_rob,
    input  logic        flush,
    output logic        full,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        cdb_valid,
    output logic [2:0]  cdb_rob,
    output logic [31:0] cdb_value,
    output logic        st_ready_valid,
    output logic [2:0]  st_ready_rob
);

    lsb_entry_t  ent_q [DEPTH];
    lsb_entry_t  ent_d [DEPTH];
    logic [2:0]  head_q, head_d, tail_q, tail_d;
    logic [3:0]  count_q, count_d;
    lsb_state_e  state_q, state_d;
    logic        kill_q, kill_d;
    logic        cdb_valid_d, st_valid_d;
    logic [2:0]  cdb_rob_d, st_rob_d;
    logic [31:0] cdb_value_d;

    lsb_entry_t  hd;
    logic        in_req, enq, pop, run;
    logic [3:0]  keep;
    logic [2:0]  scan_idx, flush_off;
    logic [31:0] ext_val;

    load_extend u_ext (
        .op_i    (hd.op),
        .rdata_i (mem_rdata),
        .value_o (ext_val)
    );

    assign hd     = ent_q[head_q];
    assign in_req = (state_q == ST_REQ);
    assign pop    = in_req && mem_ready;
    assign enq    = (is_load(op) || is_store(op)) && !flush
                    && (count_q != 4'(DEPTH));

    always_comb begin
        ent_d    = ent_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + {3'd0, enq} - {3'd0, pop};
        kill_d   = kill_q;
        keep     = '0;
        run      = 1'b1;
        scan_idx = head_q;
        flush_off = '0;

        // Commit lands before any flush in the same cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && ent_q[i].valid && is_store(ent_q[i].op)
                && ent_q[i].rob == commit_rob)
                ent_d[i].committed = 1'b1;
        end

        // Surviving prefix: committed stores, plus an in-flight head
        // load that must finish its handshake (its result is killed).
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + 3'(i);
            if (run && 4'(i) < count_q && ent_d[scan_idx].valid
                && (ent_d[scan_idx].committed || (i == 0 && in_req)))
                keep = keep + 4'd1;
            else
                run = 1'b0;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                flush_off = 3'(i) - head_q;
                if (4'(flush_off) >= keep)
                    ent_d[i].valid = 1'b0;
            end
            tail_d  = head_q + keep[2:0];
            count_d = keep - {3'd0, pop};
            if (in_req && is_load(hd.op))
                kill_d = 1'b1;
        end

        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d = head_q + 3'd1;
            kill_d = 1'b0;
        end

        if (enq) begin
            ent_d[tail_q] = '{valid: 1'b1, op: op, addr: addr,
                              data: ls_value, rob: rob_number,
                              committed: 1'b0};
            tail_d = tail_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (hd.valid && ((is_store(hd.op) && hd.committed)
                                 || (is_load(hd.op) && !flush)))
                    state_d = ST_REQ;
            ST_REQ:
                if (mem_ready)
                    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cdb_valid_d = pop && is_load(hd.op) && !kill_q && !flush;
        cdb_rob_d   = cdb_valid_d ? hd.rob : cdb_rob;
        cdb_value_d = cdb_valid_d ? ext_val : cdb_value;
        st_valid_d  = enq && is_store(op);
        st_rob_d    = st_valid_d ? rob_number : st_ready_rob;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q          <= '{default: '0};
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            state_q        <= ST_IDLE;
            kill_q         <= 1'b0;
            cdb_valid      <= 1'b0;
            cdb_rob        <= '0;
            cdb_value      <= '0;
            st_ready_valid <= 1'b0;
            st_ready_rob   <= '0;
        end else begin
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            state_q        <= state_d;
            kill_q         <= kill_d;
            cdb_valid      <= cdb_valid_d;
            cdb_rob        <= cdb_rob_d;
            cdb_value      <= cdb_value_d;
            st_ready_valid <= st_valid_d;
            st_ready_rob   <= st_rob_d;
        end
    end

    assign full      = count_q >= 4'(DEPTH - FULL_MARGIN);
    assign mem_req   = in_req;
    assign mem_we    = in_req && is_store(hd.op);
    assign mem_addr  = in_req ? hd.addr : '0;
    assign mem_wdata = mem_we ? hd.data : '0;
    assign mem_size  = in_req ? op_size(hd.op) : SIZE_B;

endmodule

// File: tb/tb_load_store_buffer.sv
// Self-checking bench for load_store_buffer: directed scenarios plus
// random traffic compared against a queue-based reference model.
module tb_load_store_buffer;
    import load_store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, ls_value, mem_addr, mem_wdata, mem_rdata, cdb_value;
    logic [4:0]  op;
    logic [2:0]  rob_number, commit_rob, cdb_rob, st_ready_rob;
    logic        commit_valid, flush, full, mem_req, mem_we, mem_ready;
    logic        cdb_valid, st_ready_valid;
    logic [1:0]  mem_size;

    always #5 clk = ~clk;

    load_store_buffer dut (
        .clk(clk), .rst(rst), .addr(addr), .op(op),
        .rob_number(rob_number), .ls_value(ls_value),
        .commit_valid(commit_valid), .commit_rob(commit_rob),
        .flush(flush), .full(full), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .cdb_valid(cdb_valid),
        .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .st_ready_valid(st_ready_valid), .st_ready_rob(st_ready_rob)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  rob;
        bit          committed;
    } mop_t;

    mop_t        mq[$];
    bit          m_busy, m_kill;
    bit          e_cdb_v, e_st_v;
    logic [2:0]  e_cdb_rob, e_st_rob, next_tag;
    logic [31:0] e_cdb_val;

    int          wait_left = -1;
    int          lat = -1;
    bit          hold_ready, use_force;
    logic [31:0] rdata_force;

    int          cdb_seen, issues;
    bit          prev_req, last_we, last_full;
    logic [31:0] last_cdb_val, last_wdata;
    logic [2:0]  last_cdb_rob, last_st_rob;

    function automatic bit m_load(input logic [4:0] o);
        return o inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
    endfunction

    function automatic bit m_store(input logic [4:0] o);
        return o inside {5'd5, 5'd6, 5'd7};
    endfunction

    function automatic logic [1:0] m_size(input logic [4:0] o);
        if (o inside {5'd1, 5'd4, 5'd6}) return 2'd1;
        if (o inside {5'd2, 5'd7}) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_ext(input logic [4:0] o,
                                          input logic [31:0] d);
        case (o)
            5'd0:    return int'(byte'(d[7:0]));
            5'd1:    return int'(shortint'(d[15:0]));
            5'd3:    return d & 32'h0000_00ff;
            5'd4:    return d & 32'h0000_ffff;
            default: return d;
        endcase
    endfunction

    task automatic check_outputs();
        check("full", full, mq.size() >= 7);
        check("mem_req", mem_req, m_busy);
        if (m_busy) begin
            check("mem_we", mem_we, m_store(mq[0].op));
            check("mem_addr", mem_addr, mq[0].addr);
            check("mem_size", mem_size, m_size(mq[0].op));
            if (m_store(mq[0].op))
                check("mem_wdata", mem_wdata, mq[0].data);
        end
        check("cdb_valid", cdb_valid, e_cdb_v);
        if (e_cdb_v) begin
            check("cdb_rob", cdb_rob, e_cdb_rob);
            check("cdb_value", cdb_value, e_cdb_val);
        end
        check("st_ready_valid", st_ready_valid, e_st_v);
        if (e_st_v)
            check("st_ready_rob", st_ready_rob, e_st_rob);
        if (cdb_valid) begin
            cdb_seen++;
            last_cdb_val = cdb_value;
            last_cdb_rob = cdb_rob;
        end
        if (st_ready_valid)
            last_st_rob = st_ready_rob;
        if (mem_req && !prev_req) begin
            issues++;
            last_we = mem_we;
            last_wdata = mem_wdata;
        end
        prev_req = mem_req;
        last_full = full;
    endtask

    task automatic model_step();
        bit pop, issue, enq;
        int pre_size, keep;
        pre_size = mq.size();
        pop = m_busy && mem_ready;
        issue = !m_busy && pre_size > 0
                && ((m_load(mq[0].op) && !flush)
                    || (m_store(mq[0].op) && mq[0].committed));
        e_cdb_v = pop && m_load(mq[0].op) && !m_kill && !flush;
        if (e_cdb_v) begin
            e_cdb_rob = mq[0].rob;
            e_cdb_val = m_ext(mq[0].op, mem_rdata);
        end
        if (commit_valid)
            foreach (mq[i])
                if (m_store(mq[i].op) && mq[i].rob == commit_rob)
                    mq[i].committed = 1'b1;
        if (flush) begin
            keep = 0;
            while (keep < mq.size()
                   && (mq[keep].committed || (keep == 0 && m_busy)))
                keep++;
            while (mq.size() > keep) void'(mq.pop_back());
            if (m_busy && m_load(mq[0].op)) m_kill = 1'b1;
        end
        enq = (op <= 5'd7) && !flush;
        assert (!(enq && pre_size == 8)) else begin
            failures++;
            $display("FAIL enq_at_count8 got=1 exp=0 t=%0t", $time);
        end
        if (pop) begin
            void'(mq.pop_front());
            m_busy = 1'b0;
            m_kill = 1'b0;
        end
        if (issue) m_busy = 1'b1;
        e_st_v = enq && pre_size < 8 && m_store(op);
        if (e_st_v) e_st_rob = rob_number;
        if (enq && pre_size < 8)
            mq.push_back('{op, addr, ls_value, rob_number, 1'b0});
    endtask

    task automatic cycle(input bit en, input logic [4:0] o,
                         input logic [31:0] a, input logic [31:0] v,
                         input logic [2:0] tag, input bit cv,
                         input logic [2:0] cr, input bit fl);
        @(negedge clk);
        check_outputs();
        mem_ready = 1'b0;
        if (m_busy) begin
            if (wait_left < 0)
                wait_left = (lat >= 0) ? lat : int'($urandom_range(0, 2));
            if (!hold_ready) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
        end
        mem_rdata = use_force ? rdata_force : $urandom();
        op = en ? o : OP_NOP;
        addr = a;
        ls_value = v;
        rob_number = tag;
        commit_valid = cv;
        commit_rob = cr;
        flush = fl;
        model_step();
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b0, OP_NOP, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic enq_op(input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] v, input logic [2:0] tag);
        cycle(1'b1, o, a, v, tag, 1'b0, '0, 1'b0);
    endtask

    task automatic rand_cycle(input bit allow_enq);
        bit en, cv, fl;
        logic [4:0] o;
        logic [2:0] cr;
        int idx;
        o = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) o = 5'($urandom_range(8, 31));
        en = allow_enq && mq.size() < 8 && ($urandom_range(0, 99) < 55);
        fl = allow_enq && ($urandom_range(0, 99) < 3);
        cv = 1'b0;
        cr = 3'($urandom());
        idx = -1;
        foreach (mq[i])
            if (idx < 0 && m_store(mq[i].op) && !mq[i].committed) idx = i;
        if (idx >= 0 && $urandom_range(0, 1) == 1) begin
            cv = 1'b1;
            cr = mq[idx].rob;
        end else if ($urandom_range(0, 9) == 0) begin
            cv = 1'b1;
        end
        cycle(en, o, $urandom(), $urandom(), next_tag, cv, cr, fl);
        if (en && !fl && o <= 5'd7) next_tag = next_tag + 3'd1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, i0;
        rst = 1'b0;
        op = OP_NOP; addr = '0; ls_value = '0; rob_number = '0;
        commit_valid = 1'b0; commit_rob = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        next_tag = '0;
        #12;
        check("rst_full", full, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_size", mem_size, 0);
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_rob", cdb_rob, 0);
        check("rst_cdb_value", cdb_value, 0);
        check("rst_st_valid", st_ready_valid, 0);
        check("rst_st_rob", st_ready_rob, 0);
        @(negedge clk);
        rst = 1'b1;

        // single LW, memory answers after 2 wait cycles
        lat = 2; use_force = 1'b1; rdata_force = 32'hDEAD_BEEF;
        c0 = cdb_seen;
        enq_op(OP_LW, 32'h100, '0, 3'd1);
        idle(8);
        check("lw_pulses", cdb_seen - c0, 1);
        check("lw_value", last_cdb_val, 32'hDEAD_BEEF);
        check("lw_rob", last_cdb_rob, 3'd1);

        // sign vs zero extension of the same byte
        lat = 0; rdata_force = 32'h0000_0080;
        enq_op(OP_LB, 32'h3, '0, 3'd3);
        idle(5);
        check("lb_value", last_cdb_val, 32'hFFFF_FF80);
        enq_op(OP_LBU, 32'h3, '0, 3'd4);
        idle(5);
        check("lbu_value", last_cdb_val, 32'h0000_0080);
        use_force = 1'b0;

        // store waits for commit
        i0 = issues;
        enq_op(OP_SW, 32'h200, 32'hCAFE_F00D, 3'd2);
        idle(5);
        check("st_ready_tag", last_st_rob, 3'd2);
        check("sw_gated", issues - i0, 0);
        cycle(1'b0, OP_NOP, '0, '0, '0, 1'b1, 3'd2, 1'b0);
        idle(5);
        check("sw_issued", issues - i0, 1);
        check("sw_we", last_we, 1);
        check("sw_wdata", last_wdata, 32'hCAFE_F00D);

        // fill with memory stalled
        hold_ready = 1'b1;
        for (int k = 0; k < 7; k++)
            enq_op(OP_LW, 32'h40 + 32'(k * 4), '0, 3'(k));
        check("full_at_6", last_full, 0);
        enq_op(OP_LW, 32'h60, '0, 3'd7);
        check("full_at_7", last_full, 1);
        hold_ready = 1'b0;
        c0 = cdb_seen;
        idle(24);
        check("full_drain_pulses", cdb_seen - c0, 8);

        // flush: committed SW survives, younger ops and new op dropped
        i0 = issues; c0 = cdb_seen;
        enq_op(OP_SW, 32'h300, 32'h1122_3344, 3'd5);
        enq_op(OP_LW, 32'h304, '0, 3'd6);
        enq_op(OP_SB, 32'h308, 32'h55, 3'd7);
        cycle(1'b1, OP_LW, 32'h30c, '0, 3'd0, 1'b1, 3'd5, 1'b1);
        idle(8);
        check("flush_issues", issues - i0, 1);
        check("flush_we", last_we, 1);
        check("flush_wdata", last_wdata, 32'h1122_3344);
        check("flush_no_cdb", cdb_seen - c0, 0);

        // flush while a load is in flight
        lat = 3; i0 = issues; c0 = cdb_seen;
        enq_op(OP_LH, 32'h400, '0, 3'd1);
        idle(2);
        cycle(1'b0, OP_NOP, '0, '0, '0, 1'b0, '0, 1'b1);
        idle(8);
        check("kill_issues", issues - i0, 1);
        check("kill_no_cdb", cdb_seen - c0, 0);

        // 20 alternating ops so the pointers wrap
        lat = 0; i0 = issues; c0 = cdb_seen;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) begin
                enq_op(OP_LW, 32'h800 + 32'(k * 4), '0, 3'(k));
                idle(1);
            end else begin
                enq_op(OP_SW, 32'h800 + 32'(k * 4), 32'(k), 3'(k));
                cycle(1'b0, OP_NOP, '0, '0, '0, 1'b1, 3'(k), 1'b0);
            end
        end
        idle(8);
        check("wrap_issues", issues - i0, 20);
        check("wrap_pulses", cdb_seen - c0, 10);

        // random traffic, then drain
        lat = -1;
        for (int k = 0; k < 1500; k++) rand_cycle(1'b1);
        for (int k = 0; k < 80; k++) rand_cycle(1'b0);

        // async reset while a request is held
        hold_ready = 1'b1;
        enq_op(OP_LW, 32'h900, '0, 3'd0);
        idle(3);
        #2 rst = 1'b0;
        #1;
        check("async_rst_req", mem_req, 0);
        check("async_rst_addr", mem_addr, 0);
        mq.delete();
        m_busy = 1'b0; m_kill = 1'b0;
        e_cdb_v = 1'b0; e_st_v = 1'b0;
        wait_left = -1; hold_ready = 1'b0; prev_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
